// File: rtl/fifo_word_reader_if.sv
// Word-wide valid/ready output stream of the FIFO drain engine.
interface fifo_word_reader_if #(
  parameter int BPW = 4
) ();
  logic [8*BPW-1:0] m_data;
  logic [BPW-1:0]   m_keep;
  logic             m_last;
  logic             m_valid;
  logic             m_ready;

  modport master (
    output m_data,
    output m_keep,
    output m_last,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_keep,
    input  m_last,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/fifo_word_reader.sv
// Read-side drain engine: pops bytes from the byte FIFO, packs BPW of them
// little-endian into one word and offers it on a valid/ready stream. A flush
// request emits whatever partial word is held, tagged with keep and last.
module fifo_word_reader #(
  parameter int BPW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [7:0]           fifo_data_out,
  output logic                 fifo_r_en,
  input  logic                 flush,
  output logic                 flush_done,
  fifo_word_reader_if.master   m
);

  localparam int CW = $clog2(BPW + 1);

  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic             rd_pend;
  logic             flush_req;
  logic [8*BPW-1:0] data_q;
  logic [BPW-1:0]   keep_q;
  logic             last_q;
  logic             valid_q;

  logic             cnt_full;
  logic             word_load;
  logic             word_last;
  logic             word_take;
  logic             req_clear;
  logic             done_next;

  assign cnt_full = (int'(cnt) == BPW);

  assign m.m_data  = data_q;
  assign m.m_keep  = keep_q;
  assign m.m_last  = last_q;
  assign m.m_valid = valid_q;

  // Next-state decode plus the FIFO read request and word-control strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_next = state;
    fifo_r_en  = 1'b0;
    word_load  = 1'b0;
    word_last  = 1'b0;
    word_take  = 1'b0;
    req_clear  = 1'b0;
    done_next  = 1'b0;
    unique case (state)
      FILL: begin
        // Count the byte still in flight so the pack register never overfills.
        fifo_r_en = !rst && !fifo_empty && !flush_req &&
                    ((int'(cnt) + int'(rd_pend)) < BPW);
        if (cnt_full) begin
          state_next = SEND;
          word_load  = 1'b1;
          word_last  = flush_req;
        end else if (flush_req && !rd_pend) begin
          if (cnt != '0) begin
            state_next = SEND;
            word_load  = 1'b1;
            word_last  = 1'b1;
          end else begin
            // Nothing buffered: the flush completes without emitting a word.
            done_next = 1'b1;
            req_clear = 1'b1;
          end
        end
      end
      SEND: begin
        if (valid_q && m.m_ready) begin
          state_next = FILL;
          word_take  = 1'b1;
          if (last_q) begin
            done_next = 1'b1;
            req_clear = 1'b1;
          end
        end
      end
      default: state_next = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  // Pack register, read tracking, flush bookkeeping and output word.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      cnt        <= '0;
      rd_pend    <= 1'b0;
      flush_req  <= 1'b0;
      data_q     <= '0;
      keep_q     <= '0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      rd_pend    <= fifo_r_en;
      flush_done <= done_next;
      // A new pulse wins over a clear so a flush coinciding with the end of
      // the previous one is kept for the next fill.
      if (flush)          flush_req <= 1'b1;
      else if (req_clear) flush_req <= 1'b0;

      if (word_take) begin
        // Clearing data keeps lanes outside m_keep at zero for the next word.
        cnt     <= '0;
        data_q  <= '0;
        keep_q  <= '0;
        last_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        if (rd_pend) begin
          for (int k = 0; k < BPW; k++) begin
            if (int'(cnt) == k) begin
              data_q[8*k +: 8] <= fifo_data_out;
              keep_q[k]        <= 1'b1;
            end
          end
          cnt <= cnt + CW'(1);
        end
        if (word_load) begin
          valid_q <= 1'b1;
          last_q  <= word_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_word_reader.sv
// Self-checking bench for fifo_word_reader: directed scenarios followed by a
// randomized run checked against a byte-stream reference model.
module tb_fifo_word_reader;

  localparam int BPW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data_out = 8'h00;
  logic       fifo_r_en;
  logic       flush = 1'b0;
  logic       flush_done;

  fifo_word_reader_if #(.BPW(BPW)) ws ();

  fifo_word_reader #(.BPW(BPW)) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_r_en     (fifo_r_en),
    .flush         (flush),
    .flush_done    (flush_done),
    .m             (ws.master)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         pops    = 0;
  int         fd_seen = 0;
  int         n_flush = 0;
  bit         rnd_on  = 1'b0;
  bit         flush_busy = 1'b0;
  logic [7:0] q[$];
  logic [7:0] exp_bytes[$];

  logic [8*BPW-1:0] prev_d;
  logic [BPW-1:0]   prev_k;
  logic             prev_l;
  logic             prev_v = 1'b0;
  logic             prev_r = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte FIFO model: read data appears the cycle after an accepted read.
  always @(posedge clk) begin
    if (fifo_r_en && q.size() > 0) begin
      fifo_data_out <= q.pop_front();
      pops++;
      fifo_empty <= (q.size() == 0);
    end
  end

  // Monitor: protocol rules and, in the random phase, the byte-stream model.
  always @(negedge clk) begin
    if (fifo_r_en) check("rd_gate", {ws.m_valid, fifo_empty}, 64'd0);
    if (prev_v && !prev_r && !rst) begin
      check("hold_valid", ws.m_valid, 64'd1);
      check("hold_data", ws.m_data, prev_d);
      check("hold_keep", ws.m_keep, prev_k);
      check("hold_last", ws.m_last, prev_l);
    end
    if (rnd_on && ws.m_valid && ws.m_ready) begin
      int n;
      n = 0;
      for (int k = 0; k < BPW; k++) if (ws.m_keep[k]) n++;
      check("keep_nonzero", n > 0, 64'd1);
      check("keep_contig", ws.m_keep, (64'd1 << n) - 64'd1);
      if (!ws.m_last) check("keep_full", n, BPW);
      for (int k = 0; k < BPW; k++) begin
        if (k < n) begin
          check("byte_avail", exp_bytes.size() > 0, 64'd1);
          if (exp_bytes.size() > 0) check("byte_data", ws.m_data[8*k +: 8], exp_bytes.pop_front());
        end else begin
          check("lane_zero", ws.m_data[8*k +: 8], 64'd0);
        end
      end
    end
    if (flush_done) begin
      fd_seen++;
      flush_busy = 1'b0;
    end
    prev_v = ws.m_valid;
    prev_r = ws.m_ready;
    prev_d = ws.m_data;
    prev_k = ws.m_keep;
    prev_l = ws.m_last;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    fifo_empty = 1'b0;
    if (rnd_on) exp_bytes.push_back(b);
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!ws.m_valid && n < max) begin
      tick();
      n++;
    end
    check("valid_seen", ws.m_valid, 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, ws.m_valid, 64'd0);
    check({tag, "_data"}, ws.m_data, 64'd0);
    check({tag, "_keep"}, ws.m_keep, 64'd0);
    check({tag, "_last"}, ws.m_last, 64'd0);
    check({tag, "_done"}, flush_done, 64'd0);
    check({tag, "_ren"}, fifo_r_en, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ws.m_ready = 1'b0;
    repeat (2) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Full word with downstream always ready.
    ws.m_ready = 1'b1;
    pops = 0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_valid(20, n);
    check("t1_latency", n, BPW + 2);
    check("t1_data", ws.m_data, 64'h44332211);
    check("t1_keep", ws.m_keep, 64'hF);
    check("t1_last", ws.m_last, 64'd0);
    tick();
    check("t1_valid_drop", ws.m_valid, 64'd0);
    repeat (3) tick();
    check("t1_reads", pops, 64'd4);

    // Backpressure: word held, no reads issued while waiting.
    ws.m_ready = 1'b0;
    pops = 0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_valid(20, n);
    check("t2_data0", ws.m_data, 64'h04030201);
    repeat (10) tick();
    check("t2_held_valid", ws.m_valid, 64'd1);
    check("t2_held_data", ws.m_data, 64'h04030201);
    check("t2_no_reads", pops, 64'd4);
    ws.m_ready = 1'b1;
    tick();
    wait_valid(20, n);
    check("t2_data1", ws.m_data, 64'h08070605);
    check("t2_keep1", ws.m_keep, 64'hF);
    tick();

    // Flush of a two-byte partial word.
    push(8'hAA); push(8'hBB);
    repeat (5) tick();
    check("t3_no_word", ws.m_valid, 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_valid(5, n);
    check("t3_latency", n, 64'd1);
    check("t3_data", ws.m_data, 64'h0000BBAA);
    check("t3_keep", ws.m_keep, 64'h3);
    check("t3_last", ws.m_last, 64'd1);
    check("t3_done_early", flush_done, 64'd0);
    tick();
    check("t3_done", flush_done, 64'd1);
    check("t3_valid_drop", ws.m_valid, 64'd0);
    tick();
    check("t3_done_pulse", flush_done, 64'd0);

    // Flush with nothing buffered.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_done_wait", flush_done, 64'd0);
    tick();
    check("t4_done", flush_done, 64'd1);
    check("t4_no_word", ws.m_valid, 64'd0);
    tick();
    check("t4_done_pulse", flush_done, 64'd0);

    // Asynchronous reset in the middle of filling.
    push(8'hC1); push(8'hC2); push(8'hC3);
    tick(); tick();
    #3 rst = 1'b1;
    #1;
    check_idle_outputs("t5_rst");
    q.delete();
    fifo_empty = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    wait_valid(20, n);
    check("t5_data", ws.m_data, 64'h88776655);
    check("t5_keep", ws.m_keep, 64'hF);
    check("t5_last", ws.m_last, 64'd0);
    tick();

    // Flush in the same cycle as a read issued with two bytes held.
    push(8'hA1); push(8'hA2);
    repeat (5) tick();
    push(8'hA3);
    flush = 1'b1;
    #1;
    check("t6_read_issue", fifo_r_en, 64'd1);
    tick();
    flush = 1'b0;
    wait_valid(5, n);
    check("t6_data", ws.m_data, 64'h00A3A2A1);
    check("t6_keep", ws.m_keep, 64'h7);
    check("t6_last", ws.m_last, 64'd1);
    tick();
    check("t6_done", flush_done, 64'd1);
    tick();

    // Randomized traffic against the byte-stream model.
    fd_seen = 0;
    rnd_on  = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      ws.m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) push(8'($urandom_range(0, 255)));
      flush = 1'b0;
      if (!flush_busy && $urandom_range(0, 60) == 0) begin
        flush = 1'b1;
        flush_busy = 1'b1;
        n_flush++;
      end
      tick();
    end
    flush = 1'b0;
    ws.m_ready = 1'b1;
    for (int c = 0; c < 300 && (q.size() != 0 || ws.m_valid || flush_busy); c++) tick();
    check("rnd_idle", {q.size() != 0, ws.m_valid, flush_busy}, 64'd0);
    flush = 1'b1;
    flush_busy = 1'b1;
    n_flush++;
    tick();
    flush = 1'b0;
    for (int c = 0; c < 50 && flush_busy; c++) tick();
    check("rnd_flush_done", flush_busy, 64'd0);
    repeat (3) tick();
    check("rnd_drained", exp_bytes.size(), 64'd0);
    check("rnd_flush_count", fd_seen, n_flush);
    rnd_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_word_reader.md
# fifo_word_reader

Read-side drain engine for the 8-bit synchronous byte FIFO. It pops bytes through the FIFO read port, packs BPW consecutive bytes into one little-endian word, and presents each word on a valid/ready output stream. A flush request emits a partial word marked with keep and last. It sits between the byte FIFO and the word-wide downstream consumer.

## Interface

- BPW, 4, bytes per output word; legal range 2..8.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  empty flag from the FIFO.
- fifo_data_out  input  8  FIFO read data, valid in the cycle after an accepted read.
- fifo_r_en  output  1  FIFO read enable.
- flush  input  1  single-cycle pulse requesting emission of the current partial word.
- m_data  output  8*BPW  packed word; byte k is the k-th popped byte and occupies bits [8k+7:8k].
- m_keep  output  BPW  byte-valid mask; bit k set means byte k is valid.
- m_last  output  1  marks the final word of a flush.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accepts the word.
- flush_done  output  1  one-cycle pulse when a flush completes.

## Operation

- **State**
  - FSM states: FILL and SEND.
  - cnt: bytes held in the pack register, width clog2(BPW+1).
  - rd_pend: set when a FIFO read was issued in the previous cycle.
  - flush_req: latched flush request.
- **Read issue (combinational):** fifo_r_en = !rst && state==FILL && !fifo_empty && !flush_req && (cnt + rd_pend) < BPW. Back-to-back reads are allowed. A read is never issued into a full pack register or while the FIFO is empty.
- **Capture:** when rd_pend=1, fifo_data_out is written into byte lane cnt, m_keep[cnt] is set, and cnt increments.
- **FILL to SEND, full word:** taken when cnt==BPW. rd_pend is necessarily 0. m_valid is set. m_last = flush_req.
- **flush pulse:** sets flush_req in any state. Once flush_req is set, no new reads are issued.
- **FILL with flush_req=1 and rd_pend=0:**
  - If cnt>0, move to SEND with a partial m_keep and m_last=1.
  - If cnt==0, no word is emitted: pulse flush_done and clear flush_req.
- **SEND:** m_data, m_keep and m_last hold stable while m_valid=1 && m_ready=0. No reads are issued in SEND.
- **Handshake in SEND (m_valid && m_ready):**
  - m_valid goes to 0, cnt to 0, m_keep to 0, state to FILL.
  - If m_last was 1, pulse flush_done, clear flush_req and clear m_last.
- **Flush while already in SEND with m_last=0:** the current word completes normally. flush_req is then handled from FILL.
- **Unused lanes:** m_data lanes not marked in m_keep are 0.

## Timing

- **Reset values:** m_valid=0, m_data=0, m_keep=0, m_last=0, flush_done=0, fifo_r_en=0. Internally state=FILL, cnt=0, rd_pend=0, flush_req=0.
- **Reset mid-operation:** asynchronous assertion discards any partial word and any pending read. Nothing resumes until rst deasserts.
- **Read latency:** a read issued at edge N is captured at edge N+1.
- **Full-word latency:** with the FIFO holding at least BPW bytes and m_ready=1, the first fifo_r_en is at cycle 0 and m_valid rises after edge BPW+1.
- **Throughput:** one word per BPW+2 cycles. There is no prefetch during SEND.
- **Flush latency:** at most 2 cycles from the flush pulse to m_valid when rd_pend was set, and 1 cycle otherwise.
- **flush_done:** registered, high for exactly one cycle.
- **Simultaneous events:**
  - flush arriving in the same cycle as a read issue: the pending byte is still captured and included.
  - flush arriving in the same cycle as the SEND handshake: flush_req is latched for the next FILL.

## Test plan

- BPW=4; write 0x11,0x22,0x33,0x44, hold m_ready=1 -> single word m_data=0x44332211, m_keep=0xF, m_last=0; fifo_r_en high exactly 4 cycles.
- Write 8 bytes 0x01..0x08; hold m_ready=0 for 10 cycles after m_valid rises -> m_data=0x04030201 stays stable and no fifo_r_en is issued. Release m_ready -> second word 0x08070605.
- Write 0xAA,0xBB; after both are captured, pulse flush -> m_data=0x0000BBAA, m_keep=0x3, m_last=1; flush_done one cycle after the handshake.
- Pulse flush with the FIFO empty and cnt=0 -> no m_valid; flush_done pulses 1 cycle later.
- Write 3 bytes, assert rst asynchronously mid-read -> all outputs 0 immediately. After release, writing 0x55,0x66,0x77,0x88 yields exactly 0x88776655.
- Pulse flush in the same cycle a read is issued with cnt=2 -> captured byte included; m_keep=0x7, m_last=1.
